// File: rtl/mod107_reduce_sched.sv
// Round-robin front end for the shared chunk-residue LUT bank: accepts one operand at a time,
// walks its CW-bit chunks through the tables and returns operand mod MOD with the requester id.
module mod107_reduce_sched #(
   parameter int NREQ = 4,
   parameter int XW   = 9,
   parameter int CW   = 6,
   parameter int MOD  = 107,
   parameter int RW   = 7,
   localparam int NCHUNK = (XW + CW - 1) / CW,
   localparam int SW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1,
   localparam int IW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*XW-1:0]   req_data,
   output logic [NREQ-1:0]      req_ready,
   output logic [SW-1:0]        lut_sel,
   output logic [CW-1:0]        lut_addr,
   input  logic [RW-1:0]        lut_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [RW-1:0]        out_data,
   output logic [IW-1:0]        out_id,
   output logic                 busy
);

   localparam int PW = NCHUNK * CW;
   localparam logic [RW:0] MOD_W = (RW + 1)'(MOD);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOOKUP = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t          state_r;
   state_t          next_state_s;
   logic [IW-1:0]   rr_ptr_r;
   logic [XW-1:0]   opnd_r;
   logic [IW-1:0]   id_r;
   logic [RW-1:0]   acc_r;
   logic [SW-1:0]   cnt_r;

   logic            found_s;
   logic [IW-1:0]   grant_s;
   logic [IW-1:0]   idx_s;
   logic [PW-1:0]   opnd_ext_s;
   logic [CW-1:0]   chunk_s;
   logic [RW:0]     sum_s;
   logic [RW-1:0]   acc_next_s;

   // Round-robin arbiter: scan descending so the entry nearest rr_ptr wins last.
   always_comb begin
      found_s = |req_valid;
      grant_s = '0;
      idx_s   = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         idx_s   = IW'((int'(rr_ptr_r) + i) % NREQ);
         grant_s = req_valid[idx_s] ? idx_s : grant_s;
      end
   end

   // Chunk extraction and modular accumulate of the current LUT result.
   always_comb begin
      opnd_ext_s = PW'(opnd_r);
      chunk_s    = CW'(opnd_ext_s >> (int'(cnt_r) * CW));
      sum_s      = {1'b0, acc_r} + {1'b0, lut_data};
      acc_next_s = (sum_s >= MOD_W) ? RW'(sum_s - MOD_W) : RW'(sum_s);
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state and output decode.
   always_comb begin
      next_state_s = state_r;
      req_ready    = '0;
      lut_sel      = '0;
      lut_addr     = '0;
      out_valid    = 1'b0;
      out_data     = '0;
      out_id       = '0;
      busy         = 1'b0;
      case (state_r)
         IDLE: begin
            if (found_s) begin
               req_ready[grant_s] = 1'b1;
               next_state_s       = LOOKUP;
            end else begin
               next_state_s = IDLE;
            end
         end
         LOOKUP: begin
            busy     = 1'b1;
            lut_sel  = cnt_r;
            lut_addr = chunk_s;
            if (cnt_r == SW'(NCHUNK - 1)) begin
               next_state_s = DONE;
            end else begin
               next_state_s = LOOKUP;
            end
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            out_data  = acc_r;
            out_id    = id_r;
            if (out_ready) begin
               next_state_s = IDLE;
            end else begin
               next_state_s = DONE;
            end
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

   // Operand capture, pointer advance and chunk accumulation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_r <= '0;
         opnd_r   <= '0;
         id_r     <= '0;
         acc_r    <= '0;
         cnt_r    <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (found_s) begin
                  opnd_r   <= req_data[int'(grant_s) * XW +: XW];
                  id_r     <= grant_s;
                  acc_r    <= '0;
                  cnt_r    <= '0;
                  rr_ptr_r <= (grant_s == IW'(NREQ - 1)) ? '0 : grant_s + IW'(1);
               end else begin
                  rr_ptr_r <= rr_ptr_r;
               end
            end
            LOOKUP: begin
               acc_r <= acc_next_s;
               cnt_r <= cnt_r + SW'(1);
            end
            DONE: begin
               acc_r <= acc_r;
            end
            default: begin
               cnt_r <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mod107_reduce_sched.sv
// Directed bench for mod107_reduce_sched: a behavioural LUT bank feeds the DUT and every
// expected residue is either hand-computed or taken from plain x % 107 arithmetic.
module tb_mod107_reduce_sched;

   localparam int NREQ = 4;
   localparam int XW   = 9;
   localparam int CW   = 6;
   localparam int MOD  = 107;
   localparam int RW   = 7;

   logic                clk;
   logic                rst_n;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ*XW-1:0]  req_data;
   logic [NREQ-1:0]     req_ready;
   logic [0:0]          lut_sel;
   logic [CW-1:0]       lut_addr;
   logic [RW-1:0]       lut_data;
   logic                out_valid;
   logic                out_ready;
   logic [RW-1:0]       out_data;
   logic [1:0]          out_id;
   logic                busy;

   int total_cnt;
   int bad_cnt;

   mod107_reduce_sched dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .lut_sel   (lut_sel),
      .lut_addr  (lut_addr),
      .lut_data  (lut_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_id    (out_id),
      .busy      (busy)
   );

   // table k holds (chunk << 6k) mod 107
   assign lut_data = RW'((int'(lut_addr) << (CW * int'(lut_sel))) % MOD);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got !== exp) begin
         bad_cnt++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_ready"}, 32'(req_ready), 32'd0);
      check_eq({tag, "_valid"}, 32'(out_valid), 32'd0);
      check_eq({tag, "_data"},  32'(out_data),  32'd0);
      check_eq({tag, "_id"},    32'(out_id),    32'd0);
      check_eq({tag, "_sel"},   32'(lut_sel),   32'd0);
      check_eq({tag, "_addr"},  32'(lut_addr),  32'd0);
      check_eq({tag, "_busy"},  32'(busy),      32'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req_valid = '0;
      #1;
      step();
      step();
      rst_n = 1'b1;
   endtask

   // single requester, out_ready high, fixed-latency timeline
   task automatic run_one(input int idx, input int x, input int exp_res);
      logic [NREQ-1:0] onehot;
      onehot = '0;
      onehot[idx] = 1'b1;
      out_ready = 1'b1;
      req_data = '0;
      req_data[idx*XW +: XW] = XW'(x);
      req_valid = onehot;
      #1;
      check_eq("grant", 32'(req_ready), 32'(onehot));
      step();
      req_valid = '0;
      check_eq("lk0_sel", 32'(lut_sel), 32'd0);
      check_eq("lk0_addr", 32'(lut_addr), 32'(x & 63));
      check_eq("lk0_busy", 32'(busy), 32'd1);
      check_eq("lk0_ready", 32'(req_ready), 32'd0);
      step();
      check_eq("lk1_sel", 32'(lut_sel), 32'd1);
      check_eq("lk1_addr", 32'(lut_addr), 32'(x >> 6));
      check_eq("lk1_valid", 32'(out_valid), 32'd0);
      step();
      check_eq("done_valid", 32'(out_valid), 32'd1);
      check_eq("done_data", 32'(out_data), 32'(exp_res));
      check_eq("done_id", 32'(out_id), 32'(idx));
      step();
      check_eq("post_valid", 32'(out_valid), 32'd0);
      check_eq("post_busy", 32'(busy), 32'd0);
   endtask

   int ops [NREQ][6];
   int op_idx [NREQ];
   int exp_q [$];
   int exp_id_q [$];
   int results;
   int k;
   int rr_data [NREQ];
   int rr_exp [NREQ];
   int acc_id;

   initial begin
      total_cnt = 0;
      bad_cnt   = 0;
      rst_n     = 1'b1;
      req_valid = '0;
      req_data  = '0;
      out_ready = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("reset");
      step();
      step();
      rst_n = 1'b1;
      step();
      check_all_zero("idle");

      // hand-computed residues
      run_one(0, 300, 86);
      run_one(2, 511, 83);
      run_one(2, 107, 0);
      run_one(2, 106, 106);
      run_one(2, 0, 0);

      // round-robin order from reset with everyone requesting
      do_reset();
      rr_data = '{5, 105, 205, 305};
      rr_exp  = '{5, 105, 98, 91};
      for (int i = 0; i < NREQ; i++) req_data[i*XW +: XW] = XW'(rr_data[i]);
      out_ready = 1'b1;
      req_valid = 4'hF;
      #1;
      for (int n = 0; n < 5; n++) begin
         k = 0;
         while (req_ready == '0 && k < 20) begin step(); k++; end
         check_eq("rr_grant", 32'(req_ready), 32'(1 << (n % NREQ)));
         step();
         k = 0;
         while (!out_valid && k < 20) begin step(); k++; end
         check_eq("rr_id", 32'(out_id), 32'(n % NREQ));
         check_eq("rr_data", 32'(out_data), 32'(rr_exp[n % NREQ]));
         step();
      end
      req_valid = '0;
      k = 0;
      while (busy && k < 20) begin step(); k++; end
      check_eq("rr_drain", 32'(busy), 32'd0);

      // stall in DONE while another requester waits
      out_ready = 1'b0;
      req_data = '0;
      req_data[1*XW +: XW] = 9'd300;
      req_valid = 4'b0010;
      #1;
      check_eq("stall_grant", 32'(req_ready), 32'b0010);
      step();
      req_valid = 4'b1000;
      k = 0;
      while (!out_valid && k < 20) begin step(); k++; end
      for (int c = 0; c < 5; c++) begin
         check_eq("stall_valid", 32'(out_valid), 32'd1);
         check_eq("stall_data", 32'(out_data), 32'd86);
         check_eq("stall_id", 32'(out_id), 32'd1);
         check_eq("stall_ready", 32'(req_ready), 32'd0);
         check_eq("stall_addr", 32'(lut_addr), 32'd0);
         step();
      end
      out_ready = 1'b1;
      step();
      check_eq("stall_next", 32'(req_ready), 32'b1000);
      req_valid = '0;
      step();
      check_eq("stall_drop", 32'(busy), 32'd0);

      // reset mid-lookup
      req_data = '0;
      req_data[0 +: XW] = 9'd300;
      req_valid = 4'b0001;
      step();
      req_valid = '0;
      check_eq("rst_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check_all_zero("rst_mid");
      step();
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step();
         check_eq("rst_nostale_valid", 32'(out_valid), 32'd0);
         check_eq("rst_nostale_busy", 32'(busy), 32'd0);
      end

      // random operands, random backpressure
      for (int i = 0; i < NREQ; i++) begin
         op_idx[i] = 0;
         for (int j = 0; j < 6; j++) ops[i][j] = int'($urandom_range(0, 511));
      end
      ops[3][0] = 511;
      ops[1][2] = 107;
      results = 0;
      for (int cyc = 0; cyc < 2000 && results < NREQ * 6; cyc++) begin
         step();
         for (int i = 0; i < NREQ; i++) begin
            if (op_idx[i] < 6) begin
               req_valid[i] = 1'b1;
               req_data[i*XW +: XW] = XW'(ops[i][op_idx[i]]);
            end else begin
               req_valid[i] = 1'b0;
            end
         end
         out_ready = 1'($urandom_range(0, 1));
         #1;
         if (req_ready != '0) begin
            acc_id = 0;
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) acc_id = i;
            exp_q.push_back(ops[acc_id][op_idx[acc_id]] % MOD);
            exp_id_q.push_back(acc_id);
            op_idx[acc_id]++;
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check_eq("rand_extra", 32'd1, 32'd0);
            end else begin
               check_eq("rand_data", 32'(out_data), 32'(exp_q.pop_front()));
               check_eq("rand_id", 32'(out_id), 32'(exp_id_q.pop_front()));
            end
            results++;
         end
      end
      check_eq("rand_count", 32'(results), 32'(NREQ * 6));
      check_eq("rand_pending", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
